mem_access_unit: RTL and testbench

- Parametrised load/store sequencer for the multicycle datapath. It replaces hard-wired word-only memory states with a single handshaked unit.
- Takes one access request from the control FSM and performs the memory transaction. Covers byte, half, word and (for XLEN=64) double sizes.
- Generates aligned address, shifted byte enables and shifted write data. Returns a sign- or zero-extended load result.
- Flags misaligned, illegal and timed-out accesses without touching memory for the first two.

---
 rtl/mem_access_unit.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-request load/store sequencer for the multicycle
// datapath. Handles b/h/w/d accesses with lane alignment, load extension,
// misaligned/illegal fault reporting and an optional response timeout.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [XLEN/8-1:0] mem_byte_enable,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp,
  output logic [XLEN/8-1:0] rmask,
  output logic [XLEN/8-1:0] wmask
);

  localparam int NB    = XLEN / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [OFFW-1:0]  off_q;

  logic [OFFW-1:0]  off;
  logic [2:0]       off3;
  logic             bad_req;
  logic [NB-1:0]    be_next;
  logic [XLEN-1:0]  wdata_next;
  logic [XLEN-1:0]  rdata_next;

  // Encodings that are never legal for this XLEN or for a store.
  function automatic logic is_illegal(input logic st, input logic [2:0] f3);
    logic bad;
    bad = (f3 == 3'b111) || (st && f3[2]);
    if (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110)) bad = 1'b1;
    return bad;
  endfunction

  // Low address bits that must be zero for an access of this size.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Unshifted lane mask for an access of this size.
  function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return NB'(8'h01);
      2'd1:    return NB'(8'h03);
      2'd2:    return NB'(8'h0F);
      default: return NB'(8'hFF);
    endcase
  endfunction

  // Truncate the right-justified load to its size and sign/zero extend.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] d,
                                                  input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = d[7:0];
    h = d[15:0];
    w = d[31:0];
    case (f3)
      3'b000:  return XLEN'(b);
      3'b001:  return XLEN'(h);
      3'b010:  return XLEN'(w);
      3'b100:  return XLEN'(d[7:0]);
      3'b101:  return XLEN'(d[15:0]);
      3'b110:  return XLEN'(d[31:0]);
      default: return d;
    endcase
  endfunction

  // Request decode: lane offset, fault check and shifted lanes/data.
  always_comb begin
    off        = addr[OFFW-1:0];
    off3       = 3'(off);
    bad_req    = is_illegal(we, funct3) || ((off3 & align_mask(funct3[1:0])) != 3'b000);
    be_next    = size_mask(funct3[1:0]) << off;
    wdata_next = wdata << {off, 3'b000};
    rdata_next = extend_load(mem_rdata >> {off_q, 3'b000}, f3_q);
  end

  // Monitor masks follow the active lanes through ACCESS and DONE.
  always_comb begin
    rmask = '0;
    wmask = '0;
    if (state == ACCESS || state == DONE) begin
      if (we_q) wmask = mem_byte_enable;
      else      rmask = mem_byte_enable;
    end
  end

  // Sequencer FSM with registered strobes, status and memory-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      we_q            <= 1'b0;
      f3_q            <= 3'b000;
      off_q           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      rdata           <= '0;
      mem_address     <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_wdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req) begin
            we_q  <= we;
            f3_q  <= funct3;
            off_q <= off;
            busy  <= 1'b1;
            if (bad_req) begin
              // Faults complete on the next cycle without any memory strobe.
              state <= FAULT;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state           <= ACCESS;
              cnt             <= '0;
              mem_read        <= !we;
              mem_write       <= we;
              mem_address     <= {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
              mem_byte_enable <= be_next;
              mem_wdata       <= wdata_next;
            end
          end
        end
        ACCESS: begin
          if (mem_resp) begin
            state     <= DONE;
            done      <= 1'b1;
            err       <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (!we_q) rdata <= rdata_next;
          end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
            state     <= DONE;
            done      <= 1'b1;
            err       <= 1'b1;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // DONE and FAULT both last exactly one cycle.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one XLEN=32 and one XLEN=64 instance,
// both with a short response timeout.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;

  // XLEN=32 instance
  logic        req, we;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, mrd;
  logic        mresp;
  logic        busy, done, err, mrd_s, mwr_s;
  logic [31:0] rdata, maddr, mwd;
  logic [3:0]  be, rmask, wmask;

  // XLEN=64 instance
  logic        req6, we6;
  logic [2:0]  f36;
  logic [63:0] addr6, wdata6, mrd6;
  logic        mresp6;
  logic        busy6, done6, err6, mrd_s6, mwr_s6;
  logic [63:0] rdata6, maddr6, mwd6;
  logic [7:0]  be6, rmask6, wmask6;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit #(.XLEN(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(f3), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_address(maddr), .mem_read(mrd_s), .mem_write(mwr_s),
    .mem_byte_enable(be), .mem_wdata(mwd), .mem_rdata(mrd),
    .mem_resp(mresp), .rmask(rmask), .wmask(wmask)
  );

  mem_access_unit #(.XLEN(64), .TIMEOUT(4)) dut64 (
    .clk(clk), .rst(rst), .req(req6), .we(we6), .funct3(f36), .addr(addr6),
    .wdata(wdata6), .busy(busy6), .done(done6), .err(err6), .rdata(rdata6),
    .mem_address(maddr6), .mem_read(mrd_s6), .mem_write(mwr_s6),
    .mem_byte_enable(be6), .mem_wdata(mwd6), .mem_rdata(mrd6),
    .mem_resp(mresp6), .rmask(rmask6), .wmask(wmask6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start32(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d);
    req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
  endtask

  task automatic start64(input logic w, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] d);
    req6 = 1'b1; we6 = w; f36 = f; addr6 = a; wdata6 = d;
  endtask

  initial begin
    rst = 1'b1;
    req = 0; we = 0; f3 = 0; addr = 0; wdata = 0; mrd = 0; mresp = 0;
    req6 = 0; we6 = 0; f36 = 0; addr6 = 0; wdata6 = 0; mrd6 = 0; mresp6 = 0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_be", be, 0);
    chk("rst_mread", mrd_s, 0);
    rst = 1'b0;
    step();

    // lb 0x103
    start32(0, 3'b000, 32'h103, 0);
    mrd = 32'h80123456;
    step();
    req = 0;
    chk("lb_mread", mrd_s, 1);
    chk("lb_addr", maddr, 32'h100);
    chk("lb_be", be, 4'b1000);
    chk("lb_rmask", rmask, 4'b1000);
    chk("lb_busy", busy, 1);
    chk("lb_done_c1", done, 0);
    mresp = 1;
    step();
    mresp = 0;
    chk("lb_done_c2", done, 1);
    chk("lb_err", err, 0);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    chk("lb_mread_off", mrd_s, 0);
    step();
    chk("lb_idle", busy, 0);

    // lbu 0x103
    start32(0, 3'b100, 32'h103, 0);
    step();
    req = 0;
    mresp = 1;
    step();
    mresp = 0;
    chk("lbu_done", done, 1);
    chk("lbu_rdata", rdata, 32'h00000080);
    step();

    // sh 0x202 with 3 wait cycles
    start32(1, 3'b001, 32'h202, 32'h0000BEEF);
    step();
    req = 0;
    for (int i = 0; i < 3; i++) begin
      chk("sh_mwrite_wait", mwr_s, 1);
      chk("sh_mread_wait", mrd_s, 0);
      chk("sh_done_wait", done, 0);
      step();
    end
    chk("sh_mwrite_4", mwr_s, 1);
    chk("sh_be", be, 4'b1100);
    chk("sh_wmask", wmask, 4'b1100);
    chk("sh_rmask", rmask, 4'b0000);
    chk("sh_wdata_hi", mwd[31:16], 16'hBEEF);
    chk("sh_addr", maddr, 32'h200);
    mresp = 1;
    step();
    mresp = 0;
    chk("sh_done", done, 1);
    chk("sh_err", err, 0);
    chk("sh_mwrite_off", mwr_s, 0);
    chk("sh_rdata_held", rdata, 32'h00000080);
    step();

    // misaligned lw 0x101
    start32(0, 3'b010, 32'h101, 0);
    step();
    req = 0;
    chk("mis_done", done, 1);
    chk("mis_err", err, 1);
    chk("mis_mread", mrd_s, 0);
    step();
    chk("mis_busy_c2", busy, 0);
    chk("mis_done_c2", done, 0);

    // timeout: lw 0x40, no response
    start32(0, 3'b010, 32'h40, 0);
    step();
    req = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_mread", mrd_s, 1);
      chk("to_done_wait", done, 0);
      step();
    end
    chk("to_mread_off", mrd_s, 0);
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_rdata_held", rdata, 32'h00000080);
    step();

    // response in the final timeout cycle
    start32(0, 3'b010, 32'h40, 0);
    mrd = 32'h12345678;
    step();
    req = 0;
    step(); step(); step();
    chk("to4_mread", mrd_s, 1);
    mresp = 1;
    step();
    mresp = 0;
    chk("to4_done", done, 1);
    chk("to4_err", err, 0);
    chk("to4_rdata", rdata, 32'h12345678);
    step();

    // async reset in 2nd ACCESS cycle
    start32(0, 3'b010, 32'h8, 0);
    step();
    req = 0;
    step();
    chk("rr_mread_pre", mrd_s, 1);
    rst = 1'b1;
    #1;
    chk("rr_mread", mrd_s, 0);
    chk("rr_busy", busy, 0);
    chk("rr_rdata", rdata, 0);
    #2;
    rst = 1'b0;
    step();

    // lw 0x8 with req held through DONE
    start32(0, 3'b010, 32'h8, 0);
    mrd = 32'hDEADBEEF;
    step();
    mresp = 1;
    step();
    mresp = 0;
    chk("b2b_done", done, 1);
    chk("b2b_rdata", rdata, 32'hDEADBEEF);
    step();
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_mread", mrd_s, 0);
    step();
    req = 0;
    chk("b2b_reaccept_busy", busy, 1);
    chk("b2b_reaccept_mread", mrd_s, 1);
    mrd = 32'h01020304;
    mresp = 1;
    step();
    mresp = 0;
    chk("b2b2_rdata", rdata, 32'h01020304);
    step();

    // illegal encodings at XLEN=32
    start32(0, 3'b011, 32'h0, 0);
    step();
    req = 0;
    chk("ill_ld32_err", err, 1);
    chk("ill_ld32_done", done, 1);
    chk("ill_ld32_mread", mrd_s, 0);
    step();
    start32(1, 3'b100, 32'h0, 0);
    step();
    req = 0;
    chk("ill_sbu_err", err, 1);
    chk("ill_sbu_mwrite", mwr_s, 0);
    step();
    start32(0, 3'b111, 32'h0, 0);
    step();
    req = 0;
    chk("ill_111_err", err, 1);
    step();

    // XLEN=64: ld 0x10
    start64(0, 3'b011, 64'h10, 0);
    mrd6 = 64'h1122334455667788;
    step();
    req6 = 0;
    chk("ld64_be", be6, 8'hFF);
    chk("ld64_addr", maddr6, 64'h10);
    mresp6 = 1;
    step();
    mresp6 = 0;
    chk("ld64_done", done6, 1);
    chk("ld64_err", err6, 0);
    chk("ld64_rdata", rdata6, 64'h1122334455667788);
    step();

    // lwu 0x14
    start64(0, 3'b110, 64'h14, 0);
    mrd6 = 64'hCAFEF00D_00000000;
    step();
    req6 = 0;
    chk("lwu64_be", be6, 8'hF0);
    chk("lwu64_addr", maddr6, 64'h10);
    mresp6 = 1;
    step();
    mresp6 = 0;
    chk("lwu64_rdata", rdata6, 64'h00000000CAFEF00D);
    step();

    // lw 0x14 sign-extends
    start64(0, 3'b010, 64'h14, 0);
    step();
    req6 = 0;
    mresp6 = 1;
    step();
    mresp6 = 0;
    chk("lw64_rdata", rdata6, 64'hFFFFFFFFCAFEF00D);
    step();

    // sh 0x6 at XLEN=64
    start64(1, 3'b001, 64'h6, 64'h0000_0000_0000_A5C3);
    step();
    req6 = 0;
    chk("sh64_be", be6, 8'hC0);
    chk("sh64_wdata_hi", mwd6[63:48], 16'hA5C3);
    mresp6 = 1;
    step();
    mresp6 = 0;
    chk("sh64_rdata_held", rdata6, 64'hFFFFFFFFCAFEF00D);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
